// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/de/coordinate
// decode, ce-gated output delay line and a frame-aligned start/stop FSM.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int H_W      = 10,
    parameter int V_W      = 10,
    parameter int PIPE_DLY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_ce,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           line_start,
    output logic           frame_start,
    output logic           running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SS   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SE   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SS   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SE   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic HP = 1'(H_POL);
    localparam logic VP = 1'(V_POL);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           de;
        logic [H_W-1:0] x;
        logic [V_W-1:0] y;
        logic           ls;
        logic           fs;
    } stage_t;

    state_t         state, state_nx;
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           h_end, v_end;
    logic           ce_q;
    stage_t         s0;
    stage_t         last;
    stage_t         pipe [0:PIPE_DLY];

    assign h_end = (h == H_LAST);
    assign v_end = (v == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // STOP only retires to IDLE on the last pixel, so frames are never cut
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (en) state_nx = RUN;
            RUN:  if (!en) state_nx = STOP;
            STOP: begin
                if (en)
                    state_nx = RUN;
                else if (pix_ce && h_end && v_end)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            h <= '0;
            v <= '0;
        end else if (pix_ce) begin
            if (h_end) begin
                h <= '0;
                v <= v_end ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    always_comb begin
        s0 = '0;
        if (state != IDLE) begin
            s0.de = (h < H_ACT) && (v < V_ACT);
            s0.hs = (h >= H_SS) && (h < H_SE);
            s0.vs = (v >= V_SS) && (v < V_SE);
            s0.x  = s0.de ? h : '0;
            s0.y  = s0.de ? v : '0;
            s0.ls = (h == '0);
            s0.fs = (h == '0) && (v == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q <= 1'b0;
            for (int i = 0; i <= PIPE_DLY; i++)
                pipe[i] <= '0;
        end else begin
            ce_q <= pix_ce;
            if (pix_ce) begin
                pipe[0] <= s0;
                for (int i = 1; i <= PIPE_DLY; i++)
                    pipe[i] <= pipe[i-1];
            end
        end
    end

    // strobes qualify with ce_q so they last one clk even when ce is sparse
    assign last        = pipe[PIPE_DLY];
    assign hsync       = HP ? last.hs : ~last.hs;
    assign vsync       = VP ? last.vs : ~last.vs;
    assign de          = last.de;
    assign x           = last.x;
    assign y           = last.y;
    assign line_start  = last.ls & ce_q;
    assign frame_start = last.fs & ce_q;
    assign running     = (state != IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default raster, small raster with
// delay line, and small active-high raster with no delay line.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b1;
    logic en = 1'b0;

    always #5 clk = ~clk;

    logic       d0_hsync, d0_vsync, d0_de, d0_ls, d0_fs, d0_run;
    logic [9:0] d0_x, d0_y;
    logic       d1_hsync, d1_vsync, d1_de, d1_ls, d1_fs, d1_run;
    logic [3:0] d1_x;
    logic [2:0] d1_y;
    logic       d2_hsync, d2_vsync, d2_de, d2_ls, d2_fs, d2_run;
    logic [3:0] d2_x;
    logic [2:0] d2_y;

    vga_timing_gen d0 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en),
        .hsync(d0_hsync), .vsync(d0_vsync), .de(d0_de),
        .x(d0_x), .y(d0_y), .line_start(d0_ls),
        .frame_start(d0_fs), .running(d0_run)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_W(4), .V_W(3)
    ) d1 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en),
        .hsync(d1_hsync), .vsync(d1_vsync), .de(d1_de),
        .x(d1_x), .y(d1_y), .line_start(d1_ls),
        .frame_start(d1_fs), .running(d1_run)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .H_W(4), .V_W(3), .PIPE_DLY(0)
    ) d2 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en),
        .hsync(d2_hsync), .vsync(d2_vsync), .de(d2_de),
        .x(d2_x), .y(d2_y), .line_start(d2_ls),
        .frame_start(d2_fs), .running(d2_run)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int fl(input logic hs, vs, d, ls, fs, run);
        return int'({hs, vs, d, ls, fs, run});
    endfunction

    typedef struct {
        int r, e, c;
        int hs, vs, de, x, y, ls, fs, run;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int e_fl;
        // d2 (active-high syncs, no delay line), one vector per clk
        tbl[0]  = '{1,0,1, 0,0,0,0,0, 0,0,0};
        tbl[1]  = '{0,1,1, 0,0,0,0,0, 0,0,1};
        tbl[2]  = '{0,1,1, 0,0,1,0,0, 1,1,1};
        tbl[3]  = '{0,1,0, 0,0,1,0,0, 0,0,1};
        for (int k = 4; k <= 10; k++)
            tbl[k] = '{0,1,1, 0,0,1,k-3,0, 0,0,1};
        tbl[11] = '{0,1,1, 0,0,0,0,0, 0,0,1};
        tbl[12] = '{0,1,1, 1,0,0,0,0, 0,0,1};
        tbl[13] = '{0,1,1, 1,0,0,0,0, 0,0,1};
        tbl[14] = '{0,1,1, 0,0,0,0,0, 0,0,1};
        tbl[15] = '{0,1,1, 0,0,1,0,1, 1,0,1};
        tbl[16] = '{1,1,1, 0,0,0,0,0, 0,0,0};
        tbl[17] = '{0,0,1, 0,0,0,0,0, 0,0,0};

        step;
        for (int i = 0; i < 18; i++) begin
            rst    = (tbl[i].r != 0);
            en     = (tbl[i].e != 0);
            pix_ce = (tbl[i].c != 0);
            step;
            e_fl = tbl[i].hs*32 + tbl[i].vs*16 + tbl[i].de*8
                 + tbl[i].ls*4 + tbl[i].fs*2 + tbl[i].run;
            chk($sformatf("tbl%0d_flags", i),
                fl(d2_hsync, d2_vsync, d2_de, d2_ls, d2_fs, d2_run), e_fl);
            chk($sformatf("tbl%0d_x", i), int'(d2_x), tbl[i].x);
            chk($sformatf("tbl%0d_y", i), int'(d2_y), tbl[i].y);
        end

        // default raster: line timing; d2 frame/vsync timing alongside
        begin
            int d0f, ls2, hsf, hsc, dec, x639, de640, y800, r;
            int f1, f2, vsf, vsc;
            d0f = -1; ls2 = -1; hsf = -1; hsc = 0; dec = 0;
            x639 = -1; de640 = -1; y800 = -1;
            f1 = -1; f2 = -1; vsf = -1; vsc = 0;
            rst = 1; en = 0; pix_ce = 1;
            step;
            chk("d0_reset_flags",
                fl(d0_hsync, d0_vsync, d0_de, d0_ls, d0_fs, d0_run), 48);
            chk("d0_reset_xy", int'(d0_x) + int'(d0_y), 0);
            rst = 0; en = 1;
            step;
            chk("d0_running", int'(d0_run), 1);
            for (int t = 1; t <= 810; t++) begin
                step;
                if (d0_fs && d0f < 0) begin
                    d0f = t;
                    chk("d0_fs_ls_de", int'({d0_ls, d0_de}), 3);
                    chk("d0_fs_xy", int'(d0_x) + int'(d0_y), 0);
                end
                if (d0f >= 0) begin
                    r = t - d0f;
                    if (r < 800) begin
                        if (!d0_hsync) begin
                            hsc++;
                            if (hsf < 0) hsf = r;
                        end
                        if (d0_de) dec++;
                    end
                    if (r == 639) x639 = int'(d0_x);
                    if (r == 640) de640 = int'(d0_de);
                    if (r > 0 && d0_ls && ls2 < 0) ls2 = r;
                    if (r == 800) y800 = int'(d0_y);
                end
                if (d2_fs) begin
                    if (f1 < 0) f1 = t;
                    else if (f2 < 0) f2 = t;
                end
                if (f1 >= 0 && f2 < 0 && d2_vsync) begin
                    vsc++;
                    if (vsf < 0) vsf = t - f1;
                end
            end
            chk("d0_latency", d0f, 3);
            chk("d0_hs_start", hsf, 656);
            chk("d0_hs_width", hsc, 96);
            chk("d0_de_width", dec, 640);
            chk("d0_line_period", ls2, 800);
            chk("d0_x_last", x639, 639);
            chk("d0_de_after_last", de640, 0);
            chk("d0_y_line1", y800, 1);
            chk("d2_latency", f1, 1);
            chk("d2_frame_period", f2 - f1, 84);
            chk("d2_vs_start", vsf, 60);
            chk("d2_vs_width", vsc, 12);
        end

        // d1 with pix_ce one clk in four
        begin
            int fa, fb, la, lb, w, mw, dr, df, hr, hf, bad;
            logic [3:0] px;
            fa = -1; fb = -1; la = -1; lb = -1; w = 0; mw = 0;
            dr = 0; df = -1; hr = 0; hf = -1; bad = 0; px = '0;
            rst = 1; en = 0; pix_ce = 1;
            step;
            chk("d1_reset_flags",
                fl(d1_hsync, d1_vsync, d1_de, d1_ls, d1_fs, d1_run), 48);
            chk("d1_reset_xy", int'(d1_x) + int'(d1_y), 0);
            rst = 0; en = 1;
            for (int k = 0; k < 500; k++) begin
                pix_ce = (k % 4 == 0);
                step;
                if (!pix_ce && d1_x != px) bad++;
                px = d1_x;
                if (d1_ls || d1_fs) w++; else w = 0;
                if (w > mw) mw = w;
                if (d1_fs) begin
                    if (fa < 0) fa = k; else if (fb < 0) fb = k;
                end
                if (d1_ls) begin
                    if (la < 0) la = k; else if (lb < 0) lb = k;
                end
                if (d1_de) dr++;
                else begin
                    if (dr > 0 && df < 0) df = dr;
                    dr = 0;
                end
                if (!d1_hsync) hr++;
                else begin
                    if (hr > 0 && hf < 0) hf = hr;
                    hr = 0;
                end
            end
            chk("ce4_frame_period", fb - fa, 336);
            chk("ce4_line_period", lb - la, 48);
            chk("ce4_strobe_width", mw, 1);
            chk("ce4_de_run", df, 32);
            chk("ce4_hsync_run", hf, 8);
            chk("ce4_hold", bad, 0);
        end

        // d1 graceful stop mid-frame, then re-raise en during STOP
        begin
            int lat, drop, fx, dc, bad, nfs, gaps;
            pix_ce = 1;
            rst = 1; en = 0;
            step;
            rst = 0; en = 1;
            step;
            lat = -1;
            for (int k = 1; k <= 10 && lat < 0; k++) begin
                step;
                if (d1_fs) lat = k;
            end
            chk("d1_latency", lat, 3);
            drop = -1; fx = 0; dc = int'(d1_de);
            for (int r = 1; r <= 83; r++) begin
                step;
                if (d1_fs) fx++;
                if (!d1_run && drop < 0) drop = r;
                if (d1_de) dc++;
                if (r == 30) en = 0;
            end
            chk("stop_drop_time", drop, 81);
            chk("stop_no_refs", fx, 0);
            chk("stop_full_frame", dc, 32);
            chk("stop_idle_flags",
                fl(d1_hsync, d1_vsync, d1_de, d1_ls, d1_fs, d1_run), 48);
            bad = 0;
            for (int k = 0; k < 10; k++) begin
                step;
                if (d1_run || d1_fs || d1_de) bad++;
            end
            chk("idle_quiet", bad, 0);

            en = 1;
            step;
            lat = -1;
            for (int k = 1; k <= 10 && lat < 0; k++) begin
                step;
                if (d1_fs) lat = k;
            end
            chk("restart_latency", lat, 3);
            nfs = -1; gaps = 0;
            for (int r = 1; r <= 90; r++) begin
                step;
                if (!d1_run) gaps++;
                if (d1_fs && nfs < 0) begin
                    nfs = r;
                    chk("restart_fs_xy", int'(d1_x) + int'(d1_y), 0);
                end
                if (r == 30) en = 0;
                if (r == 35) en = 1;
            end
            chk("reraise_no_gap", gaps, 0);
            chk("reraise_period", nfs, 84);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
